// File: rtl/ser_lsb_first.sv
// ser_lsb_first -- parallel-to-serial converter, LSB first.
//
// Accepts WIDTH-bit words over a valid/ready handshake and shifts each one
// out on a single-bit stream, one bit per t_clk cycle. A frame_start pulse
// marks the bit-0 cycle and a frame_last pulse marks the bit-(WIDTH-1)
// cycle. All stream outputs are registered and clear asynchronously in reset.
//
// Optional feature macro: SER_HOLD_BUF_EN
//   When defined, a one-word holding register lets upstream hand over the
//   next word at any point during the current frame. When undefined, a new
//   word is only accepted in IDLE or in the final bit cycle of a frame.
//
// Ports:
//   t_clk        in   clock, rising-edge active
//   r            in   asynchronous active-low reset
//   din          in   [WIDTH-1:0] parallel word to serialize
//   din_valid    in   din holds a word
//   din_ready    out  block can accept din this cycle (combinational)
//   sout         out  serial data bit, LSB first (registered)
//   sout_valid   out  sout carries a frame bit (registered)
//   frame_start  out  high in the bit-0 cycle of each frame (registered)
//   frame_last   out  high in the bit-(WIDTH-1) cycle of each frame (registered)

module ser_lsb_first #(
    parameter int WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_last
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_last_q, frame_last_d;
    logic             accept;
    logic             at_last;

`ifdef SER_HOLD_BUF_EN
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
`endif

    assign at_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    // Ready is derived from current state only, so it never depends on din_valid.
`ifdef SER_HOLD_BUF_EN
    assign din_ready = !hold_full_q;
`else
    assign din_ready = (state_q == IDLE) || at_last;
`endif

    assign accept = din_valid && din_ready;

    // Next-state logic. The output flops are computed from the next shift
    // register and counter so that the bit presented in a cycle is always
    // sh_q[0] for the frame position held in cnt_q.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
`ifdef SER_HOLD_BUF_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_d    = din;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (at_last) begin
`ifdef SER_HOLD_BUF_EN
                    // A buffered word has priority; ready is low while hold is full,
                    // so a simultaneous accept cannot happen here.
                    if (hold_full_q) begin
                        sh_d        = hold_q;
                        hold_full_d = 1'b0;
                        cnt_d       = '0;
                    end else if (accept) begin
                        sh_d  = din;
                        cnt_d = '0;
                    end else begin
                        sh_d    = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
`else
                    if (accept) begin
                        sh_d  = din;
                        cnt_d = '0;
                    end else begin
                        sh_d    = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
`endif
                end else begin
                    sh_d  = sh_q >> 1;
                    cnt_d = cnt_q + 1'b1;
`ifdef SER_HOLD_BUF_EN
                    if (accept) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
`endif
                end
            end

            default: begin
                state_d = IDLE;
                sh_d    = '0;
                cnt_d   = '0;
            end
        endcase

        sout_valid_d  = (state_d == SHIFT);
        sout_d        = sout_valid_d && sh_d[0];
        frame_start_d = sout_valid_d && (cnt_d == '0);
        frame_last_d  = sout_valid_d && (cnt_d == CNT_LAST);
    end

    // State, datapath and registered outputs; reset discards any partial frame.
    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            state_q       <= IDLE;
            sh_q          <= '0;
            cnt_q         <= '0;
            sout_q        <= 1'b0;
            sout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
`ifdef SER_HOLD_BUF_EN
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            sh_q          <= sh_d;
            cnt_q         <= cnt_d;
            sout_q        <= sout_d;
            sout_valid_q  <= sout_valid_d;
            frame_start_q <= frame_start_d;
            frame_last_q  <= frame_last_d;
`ifdef SER_HOLD_BUF_EN
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
`endif
        end
    end

    assign sout        = sout_q;
    assign sout_valid  = sout_valid_q;
    assign frame_start = frame_start_q;
    assign frame_last  = frame_last_q;

endmodule

// File: tb/tb_ser_lsb_first.sv
// tb_ser_lsb_first -- directed bench for ser_lsb_first with WIDTH=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. the cycle following that edge.

module tb_ser_lsb_first;

    localparam int WIDTH = 8;

    logic             t_clk;
    logic             r;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             frame_last;

    int numChecks = 0;
    int numPassed = 0;
    int numFailed = 0;

    ser_lsb_first #(.WIDTH(WIDTH)) dut (
        .t_clk      (t_clk),
        .r          (r),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .frame_start(frame_start),
        .frame_last (frame_last)
    );

    // 10-unit clock period.
    initial t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    // Drive the input handshake.
    task automatic applyStimulus(input logic [WIDTH-1:0] word, input logic valid);
        din       = word;
        din_valid = valid;
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic step();
        @(posedge t_clk);
        #1;
    endtask

    // One comparison: count it and report on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numChecks++;
        assert (observed === expected) numPassed++;
        else begin
            numFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Check all stream outputs for one frame bit position.
    task automatic checkBit(input string tag, input int idx, input logic expBit,
                            input logic expStart, input logic expLast);
        checkOutput($sformatf("%s_sout%0d", tag, idx), {31'd0, sout}, {31'd0, expBit});
        checkOutput($sformatf("%s_valid%0d", tag, idx), {31'd0, sout_valid}, 32'd1);
        checkOutput($sformatf("%s_start%0d", tag, idx), {31'd0, frame_start}, {31'd0, expStart});
        checkOutput($sformatf("%s_last%0d", tag, idx), {31'd0, frame_last}, {31'd0, expLast});
    endtask

    // Check that the stream is idle.
    task automatic checkIdle(input string tag);
        checkOutput({tag, "_sout"}, {31'd0, sout}, 32'd0);
        checkOutput({tag, "_valid"}, {31'd0, sout_valid}, 32'd0);
        checkOutput({tag, "_start"}, {31'd0, frame_start}, 32'd0);
        checkOutput({tag, "_last"}, {31'd0, frame_last}, 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] expWord;
        logic [15:0]      b2bBits;
        logic [7:0]       expB4;
        logic [7:0]       exp0F;

        // Reset and release just after an edge.
        r = 1'b0;
        applyStimulus('0, 1'b0);
        step();
        step();
        r = 1'b1;
        checkIdle("rst");
        checkOutput("rst_ready", {31'd0, din_ready}, 32'd1);

        // Single word 0xB4: serial sequence 0,0,1,0,1,1,0,1.
        expB4 = 8'b1011_0100;
        applyStimulus(8'hB4, 1'b1);
        checkOutput("single_ready", {31'd0, din_ready}, 32'd1);
        step();
        applyStimulus('0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkBit("single", i, expB4[i], i == 0, i == 7);
            step();
        end
        checkIdle("single_after");

        // Back-to-back 0x01 then 0x80 with din_valid held high.
        b2bBits = 16'b1000_0000_0000_0001;
        applyStimulus(8'h01, 1'b1);
        step();
        applyStimulus(8'h80, 1'b1);
        for (int i = 0; i < 16; i++) begin
            checkBit("b2b", i, b2bBits[i], (i % 8) == 0, (i % 8) == 7);
            if (i < 8) begin
`ifdef SER_HOLD_BUF_EN
                checkOutput($sformatf("b2b_ready%0d", i), {31'd0, din_ready},
                            (i == 0) ? 32'd1 : 32'd0);
`else
                checkOutput($sformatf("b2b_ready%0d", i), {31'd0, din_ready},
                            (i == 7) ? 32'd1 : 32'd0);
`endif
            end
            step();
            if (i == 7) applyStimulus('0, 1'b0);
        end
        checkIdle("b2b_after");

`ifdef SER_HOLD_BUF_EN
        // 0xFF offered at cnt==2 of a 0x00 frame is taken at once and follows with no gap.
        applyStimulus(8'h00, 1'b1);
        step();
        applyStimulus('0, 1'b0);
        step();
        step();
        applyStimulus(8'hFF, 1'b1);
        checkOutput("hold_ready_cnt2", {31'd0, din_ready}, 32'd1);
        step();
        applyStimulus('0, 1'b0);
        for (int i = 3; i < 8; i++) begin
            checkOutput($sformatf("hold_ready_cnt%0d", i), {31'd0, din_ready}, 32'd0);
            checkBit("hold_first", i, 1'b0, 1'b0, i == 7);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            checkBit("hold_second", i, 1'b1, i == 0, i == 7);
            step();
        end
        checkIdle("hold_after");
`endif

        // Reset mid-frame at cnt==3 of 0xAA, then a clean 0x0F frame.
        expWord = 8'hAA;
        applyStimulus(8'hAA, 1'b1);
        step();
        applyStimulus('0, 1'b0);
        step();
        step();
        step();
        checkBit("aa", 3, expWord[3], 1'b0, 1'b0);
        #2;
        r = 1'b0;
        #1;
        checkIdle("rst_mid");
        step();
        r = 1'b1;
        checkOutput("rst_mid_ready", {31'd0, din_ready}, 32'd1);
        checkIdle("rst_mid_release");
        step();
        checkIdle("rst_mid_residual");

        exp0F = 8'h0F;
        applyStimulus(8'h0F, 1'b1);
        step();
        applyStimulus('0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkBit("post", i, exp0F[i], i == 0, i == 7);
            step();
        end
        checkIdle("post_after");

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule

// File: doc/ser_lsb_first.md
# ser_lsb_first

Parallel-to-serial converter that sits directly upstream of the serial two's-complement stage. It accepts WIDTH-bit words through a valid/ready handshake and shifts each one out LSB-first, one bit per t_clk cycle, on a single-bit stream. It also emits a registered frame-start marker in the bit-0 cycle, which the downstream stage uses to clear its per-word "first one seen" state. It emits a frame-last marker in the final bit cycle.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32.
- t_clk  in  1  clock; all state updates on rising edge.
- r  in  1  reset; asynchronous assert, active-low, synchronous deassert by the integrator.
- din  in  WIDTH  parallel word to serialize.
- din_valid  in  1  din holds a word.
- din_ready  out  1  block can accept din this cycle; combinational from internal state.
- sout  out  1  serial data bit, LSB first; registered.
- sout_valid  out  1  sout carries a frame bit this cycle; registered.
- frame_start  out  1  high exactly in the bit-0 cycle of each frame; registered.
- frame_last  out  1  high exactly in the bit-(WIDTH-1) cycle of each frame; registered.

## Operation
- Word transfer: a word is accepted on a rising edge where din_valid && din_ready are both high. There is no downstream backpressure. Once a frame starts, its WIDTH bits go out on WIDTH consecutive cycles.
- Datapath: shift register sh[WIDTH-1:0] and bit counter cnt, $clog2(WIDTH) bits wide.
- sout = sh[0] registered. sh shifts right each frame cycle, and zeros fill the MSB.
- FSM states:
  - IDLE: sout_valid=0. On accept: load sh, cnt=0, go to SHIFT.
  - SHIFT: emit bit cnt, then increment cnt.
  - At cnt==WIDTH-1, when a next word is available (accepted this edge, or buffered): reload sh, cnt=0, stay in SHIFT. Otherwise go to IDLE.
- din_ready (no buffer): high in IDLE, or in SHIFT when cnt==WIDTH-1. Low otherwise.
- Idle outputs: sout=0, sout_valid=0, frame_start=0, frame_last=0.
- Reset (r low, any time including mid-frame):
  - State=IDLE, sh=0, cnt=0, holding register empty.
  - sout=0, sout_valid=0, frame_start=0, frame_last=0.
  - The partial frame is discarded and never resumed.
  - After r returns high, din_ready=1 on the first cycle.

## Timing
- Latency: word accepted at edge k → bit 0 on sout, with sout_valid=1 and frame_start=1, in the cycle following edge k. Bit n is valid in the cycle after edge k+n.
- frame_last coincides with bit WIDTH-1, in the cycle after edge k+WIDTH-1.
- Back-to-back: an accept on the frame_last edge gives the next frame's bit 0 in the immediately following cycle. sout_valid stays high with no gap.
- Frame spacing with a continuously valid source: one frame every WIDTH cycles; throughput is 1 bit/cycle.
- din_valid may drop without a transfer. The block does not require din to be held after the accepting edge.

## Configuration
- SER_HOLD_BUF_EN defined: adds a one-word holding register hold/hold_full.
  - din_ready = !hold_full, in any state.
  - A word accepted during SHIFT goes into hold.
  - At the frame_last edge, hold moves to sh (hold_full cleared), or a word accepted on that same edge loads sh directly when hold is empty.
  - Net effect: upstream may hand over the next word at any point during the current frame.
- SER_HOLD_BUF_EN undefined: no holding register; din_ready follows the IDLE / cnt==WIDTH-1 rule above.
- Serial output timing is identical in both builds.

## Test plan
- Reset values: WIDTH=8, drive r low mid-sim. Required response:
  - sout=0, sout_valid=0, frame_start=0, frame_last=0 immediately, without waiting for a t_clk edge.
  - din_ready=1 after release.
- Single word: din=8'hB4 accepted at edge k.
  - sout over the next 8 cycles = 0,0,1,0,1,1,0,1.
  - frame_start only in cycle 1; frame_last only in cycle 8.
  - sout_valid=0 in cycle 9.
- Back-to-back: din=8'h01 then 8'h80, with din_valid held high.
  - 16 contiguous valid cycles: 1,0×7 then 0×7,1.
  - Two frame_start pulses 8 cycles apart.
- Handshake, no buffer: din_valid held high mid-frame.
  - din_ready=0 for cnt 0..6, and no transfer occurs.
  - Accept on the cnt==7 edge.
- Handshake, SER_HOLD_BUF_EN: second word 8'hFF offered at cnt==2 → accepted at once, din_ready=0 until the frame_last edge, and 8'hFF follows with no gap.
- Reset mid-frame: assert r at cnt==3 of 8'hAA, release, then send 8'h0F.
  - No residual bits from 8'hAA.
  - The next frame is exactly 1,1,1,1,0,0,0,0 with frame_start on bit 0.
